// File: rtl/sram_arb_pkg.sv
// Shared types and limits for the multi-port SRAM arbiter: FSM state encoding,
// legal parameter ranges and the grant-index width helper.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int NPORTS_MIN = 2;
  localparam int NPORTS_MAX = 4;
  localparam int WAIT_MIN   = 0;
  localparam int WAIT_MAX   = 3;

  // Ceiling log2, never less than 1 so a grant index always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select. Both modes are one circular search; fixed
// priority simply starts the search from port 0 every time.
module arb_pick #(
  parameter int NPORTS = 2,
  parameter int GW     = 1,
  parameter int RR     = 0
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [GW-1:0]     last_grant_i,
  output logic [GW-1:0]     grant_o,
  output logic              valid_o
);

  logic [GW-1:0] base;

  assign base = (RR != 0) ? last_grant_i : GW'(NPORTS - 1);

  // Walk from the farthest offset down to the nearest so the nearest requester wins.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    for (int k = NPORTS; k >= 1; k--) begin
      if (req_i[GW'((int'(base) + k) % NPORTS)]) begin
        grant_o = GW'((int'(base) + k) % NPORTS);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// NPORTS-way arbiter for one asynchronous SRAM. Each access is a fixed
// SETUP / STROBE(WAIT+1) / HOLD sequence ending in a one-cycle ack pulse.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int AW     = 15,
  parameter int DW     = 8,
  parameter int NPORTS = 2,
  parameter int WAIT   = 1,
  parameter int RR     = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr_in,
  input  logic [NPORTS*DW-1:0] wdata_in,
  output logic [NPORTS-1:0]    ack,
  output logic [DW-1:0]        rdata,
  output logic [AW-1:0]        sram_addr,
  input  logic [DW-1:0]        sram_din,
  output logic [DW-1:0]        sram_dout,
  output logic                 ena,
  output logic                 noe,
  output logic                 nwe,
  output logic                 busy
);

  localparam int GW = clog2(NPORTS);

  if (NPORTS < NPORTS_MIN || NPORTS > NPORTS_MAX) begin : g_bad_nports
    $error("sram_arbiter: NPORTS must be within 2..4");
  end
  if (WAIT < WAIT_MIN || WAIT > WAIT_MAX) begin : g_bad_wait
    $error("sram_arbiter: WAIT must be within 0..3");
  end
  if (RR != 0 && RR != 1) begin : g_bad_rr
    $error("sram_arbiter: RR must be 0 or 1");
  end

  state_e              state_q;
  logic [1:0]          cnt_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       last_grant_q;
  logic                we_q;
  logic [NPORTS-1:0]   ack_q;
  logic [DW-1:0]       rdata_q;
  logic [AW-1:0]       sram_addr_q;
  logic [DW-1:0]       sram_dout_q;
  logic                ena_q;
  logic                noe_q;
  logic                nwe_q;

  logic [GW-1:0]       pick_idx;
  logic                pick_valid;
  logic [AW-1:0]       addr_arr  [NPORTS];
  logic [DW-1:0]       wdata_arr [NPORTS];

  for (genvar i = 0; i < NPORTS; i++) begin : g_split
    assign addr_arr[i]  = addr_in[i*AW +: AW];
    assign wdata_arr[i] = wdata_in[i*DW +: DW];
  end

  arb_pick #(
    .NPORTS (NPORTS),
    .GW     (GW),
    .RR     (RR)
  ) u_pick (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .grant_o      (pick_idx),
    .valid_o      (pick_valid)
  );

  // Handshake: a port holds req/we/addr/wdata stable while req is high; req is
  // only sampled in IDLE, and ack is a single-cycle pulse in HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      grant_q      <= '0;
      last_grant_q <= GW'(NPORTS - 1);
      we_q         <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_dout_q  <= '0;
      ena_q        <= 1'b0;
      noe_q        <= 1'b1;
      nwe_q        <= 1'b1;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q      <= pick_idx;
            last_grant_q <= pick_idx;
            we_q         <= we[pick_idx];
            sram_addr_q  <= addr_arr[pick_idx];
            ena_q        <= we[pick_idx];
            if (we[pick_idx]) sram_dout_q <= wdata_arr[pick_idx];
            state_q      <= SETUP;
          end
        end
        SETUP: begin
          cnt_q   <= 2'd0;
          noe_q   <= we_q;
          nwe_q   <= ~we_q;
          state_q <= STROBE;
        end
        STROBE: begin
          if (cnt_q == 2'(WAIT)) begin
            noe_q          <= 1'b1;
            nwe_q          <= 1'b1;
            if (!we_q) rdata_q <= sram_din;
            ack_q[grant_q] <= 1'b1;
            state_q        <= HOLD;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        HOLD: begin
          // Address and write data stay put; only the bus driver is released.
          ena_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign sram_addr = sram_addr_q;
  assign sram_dout = sram_dout_q;
  assign ena       = ena_q;
  assign noe       = noe_q;
  assign nwe       = nwe_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Parametrised successor to the two-port Oric frame-buffer SRAM controller. It arbitrates NPORTS independent requesters for one asynchronous external SRAM, with per-port read/write, a selectable arbitration mode and configurable strobe width. It sits between the capture/display engines (RGB capture, LCD refresh, future overlay or host ports) and the SRAM pins. Each transaction is a fixed-length, non-pipelined SRAM cycle acknowledged by a one-cycle pulse.

## Interface
- AW, 15, SRAM address width
- DW, 8, SRAM data width
- NPORTS, 2, requester count; legal range 2..4
- WAIT, 1, extra strobe cycles; legal range 0..3; strobe length is WAIT+1 cycles
- RR, 0, arbitration mode: 0 = fixed priority (port 0 highest), 1 = round-robin

Ports:
- clk  in  1  system clock (27 MHz)
- rst  in  1  synchronous, active-high reset
- req  in  NPORTS  per-port request level
- we  in  NPORTS  per-port write flag (1 = write, 0 = read)
- addr_in  in  NPORTS*AW  port i address at [i*AW +: AW]
- wdata_in  in  NPORTS*DW  port i write data at [i*DW +: DW]
- ack  out  NPORTS  one-cycle completion pulse to granted port
- rdata  out  DW  read data, shared by all ports, valid from the ack cycle until the next read completes
- sram_addr  out  AW  SRAM address
- sram_din  in  DW  SRAM data bus input (from the pad)
- sram_dout  out  DW  SRAM write data
- ena  out  1  tristate enable for sram_dout
- noe  out  1  SRAM output enable, active low
- nwe  out  1  SRAM write strobe, active low
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE: if any req is high, pick a winner and register grant index, addr, we and wdata. Go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle): drive sram_addr. For writes, drive ena=1 and sram_dout. noe and nwe stay high.
- STROBE (WAIT+1 cycles, counted by a 2-bit counter): reads hold noe=0; writes hold nwe=0 with ena=1. On the last STROBE cycle, reads capture sram_din into rdata at the clock edge.
- HOLD (1 cycle): noe=nwe=1. Writes keep ena=1 and address/data stable for hold time. ack[grant]=1. Next state is IDLE.
- Fixed priority: the lowest-index requesting port wins.
- Round-robin: the search starts at last_grant+1 modulo NPORTS. last_grant updates on each grant. Reset value of last_grant is NPORTS-1, so port 0 wins first.
- req is sampled only in IDLE. A request arriving mid-transaction waits for the next IDLE.
- Requesters hold req, we, addr and wdata stable until ack, and drop req in the cycle after ack. A req still high in IDLE after its ack starts a new transaction.
- Reset values: state IDLE, sram_addr=0, sram_dout=0, ena=0, noe=1, nwe=1, ack=0, rdata=0, busy=0, last_grant=NPORTS-1.
- Reset mid-transaction abandons the cycle. Strobes and ena go inactive at the reset edge, no ack is issued, and rdata is cleared.
- At most one ack bit is high in any cycle. noe and nwe are never both low. ena is never high while noe is low.

## Timing
- Cycle 0 is the IDLE cycle with req seen. Then SETUP = cycle 1, STROBE = cycles 2..2+WAIT, HOLD with ack = cycle 3+WAIT.
- Throughput: one transaction per 4+WAIT cycles (WAIT=1 gives 5 cycles, 5.4 M accesses/s at 27 MHz).
- All outputs are registered. There is no combinational path from req to ack or to the SRAM pins.
- Worst-case wait for a port under round-robin: (NPORTS-1)*(4+WAIT) cycles after its req is seen. Fixed priority gives no bound for ports other than port 0.

## Structure
- Package sram_arb_pkg holds the state enum (IDLE, SETUP, STROBE, HOLD), the legal range limits for NPORTS and WAIT, and a function clog2 used for the grant-index width.
- One sub-module, arb_pick: combinational winner select. Inputs are req, last_grant and RR; outputs are grant index and a valid flag. It is instantiated once.
- Parameter legality is checked at elaboration; illegal values raise an error.

## Test plan
- Single read, NPORTS=2, WAIT=1, SRAM model returns 8'hA5 at 15'h1234 → noe low in cycles 2–3, ack[0] in cycle 4, rdata=8'hA5.
- Single write from port 1: 15'h7FFF ← 8'h3C → ena high in cycles 1–4, nwe low in cycles 2–3, model holds 8'h3C, ack[1] in cycle 4.
- RR=0, both ports requesting continuously → port 0 acked every 5 cycles, port 1 never acked.
- RR=1, NPORTS=4, all ports requesting continuously → acks arrive in order 0,1,2,3,0, spaced 5 cycles apart.
- WAIT=3, single read → strobe lasts 4 cycles, ack in cycle 6.
- rst asserted in the second STROBE cycle of a write → next cycle has nwe=1, ena=0, no ack; after release, a pending req is served from IDLE normally.
